// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-input round-robin arbitrated mux with a one-entry registered output slot
module rr_arb_mux #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] last_grant_q, last_grant_d;

  logic [SW-1:0] grant;
  logic [SW-1:0] cand;
  logic          any_valid;
  logic          load_en;
  logic          xfer;
  logic [W-1:0]  lane [N];
  logic [W-1:0]  grant_data;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane[i] = in_data[i*W +: W];
    end
  end

  // Search starts just past the previous winner; the first valid hit wins.
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = SW'((int'(last_grant_q) + k) % N);
      if (!any_valid && in_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign grant_data = lane[grant];
  assign load_en    = !out_valid_q || out_ready;
  assign xfer       = load_en && any_valid;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && xfer && (grant == SW'(i));
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = grant_data;
      out_sel_d    = grant;
      last_grant_d = grant;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      last_grant_q <= SW'(N - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - vector table, corner sequences and random checks for rr_arb_mux
module tb_rr_arb_mux;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  rr_arb_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: one held word plus the index of the last accepted input.
  bit         m_valid;
  logic [7:0] m_data;
  int         m_sel;
  int         m_last;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_ovalid;
    logic [7:0]  exp_odata;
    logic [1:0]  exp_osel;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] DA = 32'h33221100;
  localparam logic [31:0] DB = 32'h00A50000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_sel   = 0;
    m_last  = N - 1;
  endtask

  task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Compares DUT against the model for the current cycle, then advances both across one edge.
  task automatic step();
    int         w;
    bit         load;
    logic [3:0] er;
    w    = winner(in_valid, m_last);
    load = !m_valid || out_ready;
    er   = (load && w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("model in_ready", 32'(in_ready), 32'(er));
    chk("model out_valid", 32'(out_valid), 32'(m_valid));
    chk("model out_data", 32'(out_data), 32'(m_data));
    chk("model out_sel", 32'(out_sel), 32'(m_sel));
    @(posedge clk);
    if (load && w >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[w*W +: W];
      m_sel   = w;
      m_last  = w;
    end else if (load) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    tbl.push_back('{4'b1111, DA, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{4'b1111, DA, 1'b1, 4'b0010, 1'b1, 8'h00, 2'd0});
    tbl.push_back('{4'b1111, DA, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1});
    tbl.push_back('{4'b1111, DA, 1'b1, 4'b1000, 1'b1, 8'h22, 2'd2});
    tbl.push_back('{4'b1111, DA, 1'b1, 4'b0001, 1'b1, 8'h33, 2'd3});
    tbl.push_back('{4'b1111, DA, 1'b1, 4'b0010, 1'b1, 8'h00, 2'd0});
    tbl.push_back('{4'b0100, DB, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{4'b0100, DB, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2});
    tbl.push_back('{4'b0000, DB, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2});
    tbl.push_back('{4'b0000, DB, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2});
    tbl.push_back('{4'b0001, DA, 1'b1, 4'b0001, 1'b0, 8'hA5, 2'd2});
    tbl.push_back('{4'b0000, DA, 1'b0, 4'b0000, 1'b1, 8'h00, 2'd0});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{4'b1010, DA, 1'b0, 4'b0000, 1'b1, 8'h00, 2'd0});
    tbl.push_back('{4'b1010, DA, 1'b1, 4'b0010, 1'b1, 8'h00, 2'd0});
    tbl.push_back('{4'b0000, DA, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd1});
    tbl.push_back('{4'b0000, DA, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1});

    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_data   = DA;
    out_ready = 1'b1;
    model_reset();
    #1;
    chk("reset in_ready", 32'(in_ready), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_data", 32'(out_data), 32'h0);
    chk("reset out_sel", 32'(out_sel), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].valid, tbl[i].data, tbl[i].ordy);
      chk($sformatf("tbl[%0d] in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ovalid));
      chk($sformatf("tbl[%0d] out_data", i), 32'(out_data), 32'(tbl[i].exp_odata));
      chk($sformatf("tbl[%0d] out_sel", i), 32'(out_sel), 32'(tbl[i].exp_osel));
      step();
    end

    // last_grant=3 after draining: a lone request from input 0 wins at once
    apply(4'b1000, DA, 1'b1); step();
    apply(4'b0000, DA, 1'b1); step();
    apply(4'b0000, DA, 1'b1); step();
    apply(4'b0001, DA, 1'b1);
    chk("after drain in_ready", 32'(in_ready), 32'h1);
    step();

    // Async reset mid-stream with rotation part-way round
    apply(4'b1111, DA, 1'b1); step();
    apply(4'b1111, DA, 1'b1); step();
    apply(4'b1111, DA, 1'b1);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'h0);
    chk("async rst out_data", 32'(out_data), 32'h0);
    chk("async rst out_sel", 32'(out_sel), 32'h0);
    chk("async rst in_ready", 32'(in_ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(4'b1111, DA, 1'b1);
    chk("post rst first grant", 32'(in_ready), 32'h1);
    step();

    // Withdrawal: last_grant=0, stalled with 0110, then bit 1 drops
    apply(4'b0110, DA, 1'b0);
    chk("withdraw stall in_ready", 32'(in_ready), 32'h0);
    step();
    apply(4'b0100, DA, 1'b1);
    chk("withdraw grant", 32'(in_ready), 32'h4);
    step();
    apply(4'b0000, DA, 1'b1);
    chk("withdraw out_sel", 32'(out_sel), 32'h2);
    chk("withdraw out_data", 32'(out_data), 32'h22);
    step();

    for (int i = 0; i < 400; i++) begin
      apply(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
